// File: rtl/compress_frontend.sv
// compress_frontend: upstream stage of the dictionary compressor.
// Packs up to WORD_BYTES input bytes into one word, issues a single compress
// command to the dictionary, captures the returned code and queues
// {last, code} entries in a small output FIFO for the packet stage.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   in_valid/in_ready     byte stream handshake; in_data byte, in_last ends frame
//   dict_cmd/dict_data    command (00 idle, 01 compress) and word to compress
//   dict_resp/dict_code   response (01 ok, else error) and returned code
//   out_valid/out_ready   code FIFO handshake; out_code head code, out_last frame end
//   err                   sticky dictionary-error flag
// Optional feature (macro CMP_FE_STATS_EN): adds stat_words / stat_errs
// saturating counters of issued words and error responses.
module compress_frontend #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned WORD_BYTES = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [7:0]              in_data,
  input  logic                    in_last,
  output logic [1:0]              dict_cmd,
  output logic [8*WORD_BYTES-1:0] dict_data,
  input  logic [1:0]              dict_resp,
  input  logic [7:0]              dict_code,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [7:0]              out_code,
  output logic                    out_last,
  output logic                    err
`ifdef CMP_FE_STATS_EN
  ,
  output logic [31:0]             stat_words,
  output logic [15:0]             stat_errs
`endif
);

  localparam int unsigned DW    = 8 * WORD_BYTES;
  localparam int unsigned CNT_W = $clog2(WORD_BYTES);
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CW    = AW + 1;

  typedef enum logic [1:0] {COLLECT, ISSUE, WAIT, PUSH} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DW-1:0]     word_q, word_d;
  logic              last_q, last_d;
  logic [7:0]        code_q, code_d;
  logic              err_q, err_d;

  logic              in_ready_q;
  logic [1:0]        dict_cmd_q;
  logic [DW-1:0]     dict_data_q;
  logic              out_valid_q;
  logic [7:0]        out_code_q;
  logic              out_last_q;

  logic [8:0]        mem_q [FIFO_DEPTH];
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [8:0]        push_entry, head_d;
  logic              push, pop, full, accept, resp_ok;

  assign accept     = in_valid & in_ready_q;
  assign pop        = out_valid_q & out_ready;
  assign full       = (count_q == CW'(FIFO_DEPTH));
  assign resp_ok    = (dict_resp == 2'b01);
  assign push_entry = {last_q, code_q};

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
      word_q  <= '0;
      last_q  <= 1'b0;
      code_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      last_q  <= last_d;
      code_q  <= code_d;
      err_q   <= err_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    last_d  = last_q;
    code_d  = code_q;
    err_d   = err_q;
    push    = 1'b0;
    case (state_q)
      COLLECT: begin
        if (accept) begin
          for (int k = 0; k < WORD_BYTES; k++) begin
            if (cnt_q == CNT_W'(k)) word_d[8*k +: 8] = in_data;
          end
          cnt_d  = cnt_q + CNT_W'(1);
          last_d = in_last;
          if (in_last || cnt_q == CNT_W'(WORD_BYTES - 1)) state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (resp_ok) begin
          code_d  = dict_code;
          state_d = PUSH;
        end else begin
          // Failed word is dropped; earlier FIFO entries keep their last flag.
          err_d   = 1'b1;
          cnt_d   = '0;
          word_d  = '0;
          last_d  = 1'b0;
          state_d = COLLECT;
        end
      end
      PUSH: begin
        if (!full || pop) begin
          push    = 1'b1;
          cnt_d   = '0;
          word_d  = '0;
          last_d  = 1'b0;
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // FIFO pointer / occupancy bookkeeping
  always_comb begin
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // Entry being pushed becomes the head when it lands on the next read slot.
    head_d = (push && rd_ptr_d == wr_ptr_q) ? push_entry : mem_q[rd_ptr_d];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) mem_q[wr_ptr_q] <= push_entry;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Registered outputs, computed from next state so they align with it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_ready_q  <= 1'b1;
      dict_cmd_q  <= 2'b00;
      dict_data_q <= '0;
      out_valid_q <= 1'b0;
      out_code_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      in_ready_q  <= (state_d == COLLECT);
      dict_cmd_q  <= (state_d == ISSUE) ? 2'b01 : 2'b00;
      if (state_d == ISSUE) dict_data_q <= word_d;
      out_valid_q <= (count_d != '0);
      out_code_q  <= (count_d != '0) ? head_d[7:0] : 8'h00;
      out_last_q  <= (count_d != '0) ? head_d[8] : 1'b0;
    end
  end

  assign in_ready  = in_ready_q;
  assign dict_cmd  = dict_cmd_q;
  assign dict_data = dict_data_q;
  assign out_valid = out_valid_q;
  assign out_code  = out_code_q;
  assign out_last  = out_last_q;
  assign err       = err_q;

`ifdef CMP_FE_STATS_EN
  logic [31:0] stat_words_q;
  logic [15:0] stat_errs_q;

  // Saturating activity counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_words_q <= '0;
      stat_errs_q  <= '0;
    end else begin
      if (state_d == ISSUE && stat_words_q != '1) stat_words_q <= stat_words_q + 32'd1;
      if (state_q == WAIT && !resp_ok && stat_errs_q != '1) stat_errs_q <= stat_errs_q + 16'd1;
    end
  end

  assign stat_words = stat_words_q;
  assign stat_errs  = stat_errs_q;
`endif

endmodule
